// File: rtl/led_pattern_gen.sv
// LED pattern generator: steps a count, chase, bounce or blink pattern once
// every TICK_DIV clocks and pulses tick alongside each new pattern.
module led_pattern_gen #(
  parameter int N_LED    = 3,
  parameter int TICK_DIV = 10000000,
  parameter int CNT_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  mode_e            mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_LED-1:0] led_q, led_d;
  logic             bdir_q, bdir_d;   // bounce direction: 0 toward MSB, 1 toward LSB
  logic             tick_q;

  logic             mode_chg;
  logic             step;
  logic [N_LED-1:0] shl, shr, rotl, rotr, init_pat;

  // A mode change always wins over a step that would land on the same edge.
  always_comb begin
    mode_chg = (mode != mode_q);
    step     = en && !mode_chg && (cnt_q == CNT_W'(TICK_DIV - 1));
  end

  always_comb begin
    shl    = led_q << 1;
    shr    = led_q >> 1;
    rotl   = shl | (led_q >> (N_LED - 1));
    rotr   = shr | (led_q << (N_LED - 1));
    led_d  = led_q;
    bdir_d = bdir_q;
    case (mode_q)
      MODE_COUNT:  led_d = dir ? (led_q - N_LED'(1)) : (led_q + N_LED'(1));
      MODE_CHASE:  led_d = dir ? rotr : rotl;
      MODE_BOUNCE: begin
        // A single LED has nowhere to move, so it simply holds.
        if (N_LED > 1) begin
          led_d = bdir_q ? shr : shl;
          if (led_d[N_LED-1])  bdir_d = 1'b1;
          else if (led_d[0])   bdir_d = 1'b0;
        end
      end
      MODE_BLINK:  led_d = {N_LED{~|led_q}};
      default:     led_d = led_q;
    endcase
  end

  always_comb begin
    init_pat = '0;
    if (mode == 2'(MODE_CHASE) || mode == 2'(MODE_BOUNCE)) init_pat = N_LED'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_COUNT;
      cnt_q  <= '0;
      led_q  <= '0;
      bdir_q <= 1'b0;
      tick_q <= 1'b0;
    end else if (mode_chg) begin
      mode_q <= mode_e'(mode);
      cnt_q  <= '0;
      led_q  <= init_pat;
      bdir_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= step;
      if (en) cnt_q <= step ? '0 : (cnt_q + CNT_W'(1));
      if (step) begin
        led_q  <= led_d;
        bdir_q <= bdir_d;
      end
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LED=4, TICK_DIV=4.
module tb_led_pattern_gen;

  localparam int N_LED    = 4;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic [N_LED-1:0] led;
  logic             tick;

  int n_checks = 0;
  int n_errors = 0;

  led_pattern_gen #(.N_LED(N_LED), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .mode (mode),
    .dir  (dir),
    .led  (led),
    .tick (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp_led, input logic exp_tick);
    check({tag, "_led"}, 32'(led), 32'(exp_led));
    check({tag, "_tick"}, 32'(tick), 32'(exp_tick));
  endtask

  // One full step period: three quiet cycles, then the new pattern with tick.
  task automatic run_step(input string tag, input logic [3:0] exp_led);
    for (int i = 0; i < TICK_DIV - 1; i++) begin
      cyc();
      check({tag, "_idle_tick"}, 32'(tick), 32'd0);
    end
    cyc();
    chk_out(tag, exp_led, 1'b1);
  endtask

  initial begin
    logic [3:0] bounce_seq [10];
    bounce_seq = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4};

    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 2'd0;
    dir   = 1'b0;
    #2;
    chk_out("reset", 4'h0, 1'b0);
    cyc();
    cyc();
    chk_out("in_reset", 4'h0, 1'b0);
    rst_n = 1'b1;

    // Count up through a full wrap.
    for (int s = 1; s <= 16; s++) run_step($sformatf("count_up%0d", s), 4'(s));

    // Chase left, then right after dir changes.
    mode = 2'd1;
    cyc();
    chk_out("chase_load", 4'h1, 1'b0);
    run_step("chase_l1", 4'h2);
    run_step("chase_l2", 4'h4);
    run_step("chase_l3", 4'h8);
    run_step("chase_l4", 4'h1);
    dir = 1'b1;
    run_step("chase_r1", 4'h8);
    run_step("chase_r2", 4'h4);
    run_step("chase_r3", 4'h2);
    run_step("chase_r4", 4'h1);
    run_step("chase_r5", 4'h8);

    // Bounce, toggling dir to show it is ignored.
    mode = 2'd2;
    cyc();
    chk_out("bounce_load", 4'h1, 1'b0);
    for (int s = 0; s < 10; s++) begin
      dir = ~dir;
      run_step($sformatf("bounce%0d", s), bounce_seq[s]);
    end

    // Short reset pulse while led=4 is moving down.
    #2 rst_n = 1'b0;
    #1;
    chk_out("midrst", 4'h0, 1'b0);
    #2 rst_n = 1'b1;
    cyc();
    chk_out("post_rst_reload", 4'h1, 1'b0);
    run_step("post_rst_b1", 4'h2);
    run_step("post_rst_b2", 4'h4);

    // Mode change with the counter at TICK_DIV-1 suppresses the step.
    cyc();
    cyc();
    cyc();
    mode = 2'd3;
    cyc();
    chk_out("blink_load", 4'h0, 1'b0);
    run_step("blink1", 4'hF);
    run_step("blink2", 4'h0);

    // Freeze with en=0 partway through a period.
    cyc();
    cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_out($sformatf("freeze%0d", i), 4'h0, 1'b0);
    end
    en = 1'b1;
    cyc();
    chk_out("thaw1", 4'h0, 1'b0);
    cyc();
    chk_out("thaw2", 4'hF, 1'b1);

    // Count down from zero wraps to all-ones, then back up.
    mode = 2'd0;
    dir  = 1'b1;
    cyc();
    chk_out("down_load", 4'h0, 1'b0);
    run_step("down1", 4'hF);
    run_step("down2", 4'hE);
    dir = 1'b0;
    run_step("up_again1", 4'hF);
    run_step("up_again2", 4'h0);
    cyc();
    check("tick_single", 32'(tick), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
